// File: rtl/fpu_seq_ctrl_pkg.sv
// Shared definitions for the FPU sequencing controller.
//  - FPU opcode encodings (14 legal ops)
//  - FSM state encoding
//  - bus widths and default per-class latencies
package fpu_seq_ctrl_pkg;

  localparam int BUS_WIDTH = 64;
  localparam int OP_LEN    = 5;
  localparam int CNT_W     = 4;

  localparam int LAT_ADD  = 2;
  localparam int LAT_MUL  = 3;
  localparam int LAT_DIV  = 8;
  localparam int LAT_SQRT = 8;
  localparam int LAT_MISC = 1;

  localparam logic [OP_LEN-1:0] OP_FADD_D   = 5'b00000;
  localparam logic [OP_LEN-1:0] OP_FSUB_D   = 5'b00001;
  localparam logic [OP_LEN-1:0] OP_FMUL_D   = 5'b00010;
  localparam logic [OP_LEN-1:0] OP_FDIV_D   = 5'b00011;
  localparam logic [OP_LEN-1:0] OP_FSQRT_D  = 5'b00100;
  localparam logic [OP_LEN-1:0] OP_FCVT_L_D = 5'b00101;
  localparam logic [OP_LEN-1:0] OP_FCVT_D_L = 5'b00110;
  localparam logic [OP_LEN-1:0] OP_FMV_X_D  = 5'b00111;
  localparam logic [OP_LEN-1:0] OP_FMV_D_X  = 5'b01000;
  localparam logic [OP_LEN-1:0] OP_FADD_S   = 5'b01001;
  localparam logic [OP_LEN-1:0] OP_FSUB_S   = 5'b01010;
  localparam logic [OP_LEN-1:0] OP_FMUL_S   = 5'b01011;
  localparam logic [OP_LEN-1:0] OP_FDIV_S   = 5'b01100;
  localparam logic [OP_LEN-1:0] OP_FSQRT_S  = 5'b01101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fpu_seq_ctrl_if.sv
// Bus bundle between issue logic, the sequencing controller and the FPU.
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high; the sender keeps its payload
// stable while valid is high and ready is low.
//  req_*  : issue -> controller request channel (req_ready from controller)
//  rsp_*  : controller -> consumer response channel (rsp_ready from consumer)
//  fpu_*  : controller drives op/in1/in2 to the FPU, FPU returns fpu_out
// modport master: issue/consumer/FPU side.  modport slave: the controller.
interface fpu_seq_ctrl_if;
  import fpu_seq_ctrl_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [OP_LEN-1:0]    req_op;
  logic [BUS_WIDTH-1:0] req_in1;
  logic [BUS_WIDTH-1:0] req_in2;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [BUS_WIDTH-1:0] rsp_data;
  logic                 rsp_illegal;

  logic [OP_LEN-1:0]    fpu_op;
  logic [BUS_WIDTH-1:0] fpu_in1;
  logic [BUS_WIDTH-1:0] fpu_in2;
  logic [BUS_WIDTH-1:0] fpu_out;

  modport master (
    output req_valid, req_op, req_in1, req_in2, rsp_ready, fpu_out,
    input  req_ready, rsp_valid, rsp_data, rsp_illegal, fpu_op, fpu_in1, fpu_in2
  );

  modport slave (
    input  req_valid, req_op, req_in1, req_in2, rsp_ready, fpu_out,
    output req_ready, rsp_valid, rsp_data, rsp_illegal, fpu_op, fpu_in1, fpu_in2
  );

endinterface

// File: rtl/fpu_seq_ctrl_lat_lut.sv
// fpu_lat_lut: combinational opcode -> {legal, LAT-1} mapping.
//  op     in  OP_LEN  FPU opcode
//  legal  out 1       opcode is one of the 14 supported ops
//  lat_m1 out CNT_W   latency minus one, truncated to CNT_W (0 when illegal)
module fpu_lat_lut
  import fpu_seq_ctrl_pkg::*;
#(
  parameter int CNT_W_P    = CNT_W,
  parameter int LAT_ADD_P  = LAT_ADD,
  parameter int LAT_MUL_P  = LAT_MUL,
  parameter int LAT_DIV_P  = LAT_DIV,
  parameter int LAT_SQRT_P = LAT_SQRT,
  parameter int LAT_MISC_P = LAT_MISC
) (
  input  logic [OP_LEN-1:0]  op,
  output logic               legal,
  output logic [CNT_W_P-1:0] lat_m1
);

  localparam logic [CNT_W_P-1:0] M1_ADD  = CNT_W_P'(LAT_ADD_P - 1);
  localparam logic [CNT_W_P-1:0] M1_MUL  = CNT_W_P'(LAT_MUL_P - 1);
  localparam logic [CNT_W_P-1:0] M1_DIV  = CNT_W_P'(LAT_DIV_P - 1);
  localparam logic [CNT_W_P-1:0] M1_SQRT = CNT_W_P'(LAT_SQRT_P - 1);
  localparam logic [CNT_W_P-1:0] M1_MISC = CNT_W_P'(LAT_MISC_P - 1);

  always_comb begin
    legal  = 1'b1;
    lat_m1 = M1_MISC;
    case (op)
      OP_FADD_D, OP_FSUB_D, OP_FADD_S, OP_FSUB_S: lat_m1 = M1_ADD;
      OP_FMUL_D, OP_FMUL_S:                       lat_m1 = M1_MUL;
      OP_FDIV_D, OP_FDIV_S:                       lat_m1 = M1_DIV;
      OP_FSQRT_D, OP_FSQRT_S:                     lat_m1 = M1_SQRT;
      OP_FCVT_L_D, OP_FCVT_D_L,
      OP_FMV_X_D, OP_FMV_D_X:                     lat_m1 = M1_MISC;
      default: begin
        legal  = 1'b0;
        lat_m1 = '0;
      end
    endcase
  end

endmodule

// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: accepts one FP request at a time, holds the FPU inputs
// stable for the opcode's latency (so FPU paths can be multicycle), then
// captures fpu_out and offers it on the response channel.
//  clk, rst    clock / asynchronous active-high reset
//  flush       synchronous abort: next state IDLE, response dropped
//  bus         fpu_seq_ctrl_if.slave (request, response and FPU signals)
//  busy        state != IDLE (registered)
//  dbg_state   current FSM state
module fpu_seq_ctrl
  import fpu_seq_ctrl_pkg::*;
#(
  parameter int CNT_W_P    = CNT_W,
  parameter int LAT_ADD_P  = LAT_ADD,
  parameter int LAT_MUL_P  = LAT_MUL,
  parameter int LAT_DIV_P  = LAT_DIV,
  parameter int LAT_SQRT_P = LAT_SQRT,
  parameter int LAT_MISC_P = LAT_MISC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  fpu_seq_ctrl_if.slave bus,
  output logic         busy,
  output state_t       dbg_state
);

  state_t               state;
  logic [CNT_W_P-1:0]   cnt;
  logic [OP_LEN-1:0]    op_q;
  logic [BUS_WIDTH-1:0] in1_q;
  logic [BUS_WIDTH-1:0] in2_q;
  logic [BUS_WIDTH-1:0] rsp_data_q;
  logic                 rsp_valid_q;
  logic                 rsp_illegal_q;
  logic                 req_ready_q;

  logic                 op_legal;
  logic [CNT_W_P-1:0]   op_lat_m1;

  fpu_lat_lut #(
    .CNT_W_P   (CNT_W_P),
    .LAT_ADD_P (LAT_ADD_P),
    .LAT_MUL_P (LAT_MUL_P),
    .LAT_DIV_P (LAT_DIV_P),
    .LAT_SQRT_P(LAT_SQRT_P),
    .LAT_MISC_P(LAT_MISC_P)
  ) u_lat_lut (
    .op    (bus.req_op),
    .legal (op_legal),
    .lat_m1(op_lat_m1)
  );

  // All outputs are registered alongside the state so they change only on
  // the edge that changes the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      op_q          <= '0;
      in1_q         <= '0;
      in2_q         <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      req_ready_q   <= 1'b1;
      busy          <= 1'b0;
    end else if (flush) begin
      // Flush wins over any simultaneous accept or response handshake.
      state       <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            in1_q       <= bus.req_in1;
            in2_q       <= bus.req_in2;
            req_ready_q <= 1'b0;
            busy        <= 1'b1;
            if (op_legal) begin
              cnt   <= op_lat_m1;
              state <= ST_EXEC;
            end else begin
              // Illegal ops never wait on the FPU.
              rsp_data_q    <= '0;
              rsp_illegal_q <= 1'b1;
              rsp_valid_q   <= 1'b1;
              state         <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W_P'(1);
          end else begin
            rsp_data_q    <= bus.fpu_out;
            rsp_illegal_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          // No same-cycle re-accept: req_ready returns one edge later.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign bus.fpu_op      = op_q;
  assign bus.fpu_in1     = in1_q;
  assign bus.fpu_in2     = in2_q;
  assign dbg_state       = state;

endmodule
